// File: rtl/adder_result_accumulator.sv
// Frame accumulator for registered adder results: sums COUNT samples
// (or fewer on flush) and presents {sum, count, ovf} on a valid/ready port.
module adder_result_accumulator #(
    parameter int DATA_W = 33,
    parameter int ACC_W  = 40,
    parameter int COUNT  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic             close;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;

    assign in_ready = (state == ACCUM) & ~rst;
    assign accept   = in_valid & in_ready;

    // Extra top bit of acc_sum is the wrap-around carry for the sticky flag.
    always_comb begin
        acc_sum = {1'b0, acc}
                + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
        acc_nxt = acc;
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (accept) begin
            acc_nxt = acc_sum[ACC_W-1:0];
            cnt_nxt = cnt + 1'b1;
            ovf_nxt = ovf | acc_sum[ACC_W];
        end
    end

    always_comb begin
        close = 1'b0;
        if (state == ACCUM) begin
            close = (accept & (cnt == LAST))
                  | (flush & ((cnt != '0) | accept));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                    ovf <= ovf_nxt;
                    if (close) begin
                        out_sum   <= acc_nxt;
                        out_count <= cnt_nxt;
                        out_ovf   <= ovf_nxt;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    // Frame result is only released by the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Scoreboard bench: two accumulator widths (40 and 34 bits) driven in lockstep
// and checked against a frame-level reference model.
module tb_adder_result_accumulator;

    localparam int DW  = 33;
    localparam int CNT = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          flush = 1'b0;
    logic          clear = 1'b0;
    logic          out_ready = 1'b0;

    logic          rdy_a, ov_a, of_a;
    logic [39:0]   sum_a;
    logic [CW-1:0] cnt_a;
    logic          rdy_b, ov_b, of_b;
    logic [33:0]   sum_b;
    logic [CW-1:0] cnt_b;

    always #5 clk = ~clk;

    adder_result_accumulator #(
        .DATA_W(DW), .ACC_W(40), .COUNT(CNT), .CNT_W(CW)
    ) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
        .flush(flush), .clear(clear),
        .out_valid(ov_a), .out_ready(out_ready),
        .out_sum(sum_a), .out_count(cnt_a), .out_ovf(of_a)
    );

    adder_result_accumulator #(
        .DATA_W(DW), .ACC_W(34), .COUNT(CNT), .CNT_W(CW)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .flush(flush), .clear(clear),
        .out_valid(ov_b), .out_ready(out_ready),
        .out_sum(sum_b), .out_count(cnt_b), .out_ovf(of_b)
    );

    typedef struct {
        longint unsigned sum;
        int              n;
    } frame_t;

    frame_t q[$];

    int nchk = 0;
    int nerr = 0;

    // Reference model: samples of the open frame plus "result pending" flag.
    longint unsigned m_sum = 0;
    int              m_n = 0;
    bit              m_hold = 0;
    bit              m_cleared = 0;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero_outs(input string nm);
        chk({nm, "_valid_a"}, 64'(ov_a), 0);
        chk({nm, "_sum_a"}, 64'(sum_a), 0);
        chk({nm, "_count_a"}, 64'(cnt_a), 0);
        chk({nm, "_ovf_a"}, 64'(of_a), 0);
        chk({nm, "_valid_b"}, 64'(ov_b), 0);
        chk({nm, "_sum_b"}, 64'(sum_b), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #(2 + $urandom_range(0, 2));
        rst = 1'b1;
        #1;
        chk_zero_outs("reset");
        chk("reset_in_ready_a", 64'(rdy_a), 0);
        chk("reset_in_ready_b", 64'(rdy_b), 0);
        m_sum = 0;
        m_n = 0;
        m_hold = 0;
        m_cleared = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic cycle(input bit v, input logic [DW-1:0] d,
                         input bit fl, input bit cl, input bit ordy);
        frame_t f;
        @(negedge clk);
        chk("out_valid_a", 64'(ov_a), 64'(m_hold));
        chk("out_valid_b", 64'(ov_b), 64'(m_hold));
        chk("in_ready_a", 64'(rdy_a), 64'(!m_hold));
        chk("in_ready_b", 64'(rdy_b), 64'(!m_hold));
        if (m_cleared) chk_zero_outs("clear");
        in_valid  = v;
        in_data   = d;
        flush     = fl;
        clear     = cl;
        out_ready = ordy;
        m_cleared = 0;
        if (cl) begin
            m_sum = 0;
            m_n = 0;
            m_hold = 0;
            m_cleared = 1;
        end else if (m_hold) begin
            if (ordy) m_hold = 0;
        end else begin
            if (v) begin
                m_sum += longint'(d);
                m_n++;
            end
            if (m_n == CNT || (fl && m_n > 0)) begin
                f.sum = m_sum;
                f.n = m_n;
                q.push_back(f);
                m_hold = 1;
                m_sum = 0;
                m_n = 0;
            end
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, ordy);
    endtask

    // Monitor: each new presentation of a frame result is matched to the queue.
    initial begin
        bit prev = 0;
        frame_t f;
        longint unsigned m40;
        longint unsigned m34;
        m40 = (64'd1 << 40) - 1;
        m34 = (64'd1 << 34) - 1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && ov_a && !prev) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_frame", 64'(ov_a), 0);
                end else begin
                    f = q.pop_front();
                    chk("sum_a", 64'(sum_a), f.sum & m40);
                    chk("ovf_a", 64'(of_a), 64'(f.sum > m40));
                    chk("count_a", 64'(cnt_a), 64'(f.n));
                    chk("sum_b", 64'(sum_b), f.sum & m34);
                    chk("ovf_b", 64'(of_b), 64'(f.sum > m34));
                    chk("count_b", 64'(cnt_b), 64'(f.n));
                    chk("valid_b", 64'(ov_b), 1);
                end
            end
            prev = rst ? 1'b0 : ov_a;
        end
    end

    initial begin
        logic [DW-1:0] mx;
        logic [DW-1:0] d;
        mx = '1;
        #1;
        chk_zero_outs("por");
        do_reset();

        // Basic 4-sample frame
        for (int i = 1; i <= 4; i++) cycle(1, DW'(i), 0, 0, 1);
        idle(2, 1);

        // Full-scale samples; narrow instance wraps
        for (int i = 0; i < 4; i++) cycle(1, mx, 0, 0, 1);
        idle(2, 1);
        for (int i = 0; i < 3; i++) cycle(1, mx, 0, 0, 1);
        cycle(1, '0, 0, 0, 1);
        idle(2, 1);

        // Backpressure: held result, inputs refused
        for (int i = 0; i < 4; i++) cycle(1, DW'(100 + i), 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, DW'(77), 0, 0, 0);
        cycle(1, DW'(77), 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, DW'(2), 0, 0, 1);
        idle(2, 1);

        // Flush cases
        cycle(1, DW'(5), 0, 0, 1);
        cycle(1, DW'(7), 0, 0, 1);
        cycle(0, '0, 1, 0, 1);
        idle(2, 1);
        cycle(0, '0, 1, 0, 1);
        idle(2, 1);
        cycle(1, DW'(5), 0, 0, 1);
        cycle(1, DW'(7), 0, 0, 1);
        cycle(1, DW'(9), 1, 0, 1);
        idle(2, 1);

        // Reset mid-frame
        cycle(1, DW'(50), 0, 0, 1);
        cycle(1, DW'(60), 0, 0, 1);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, DW'(1), 0, 0, 1);
        idle(2, 1);

        // Clear in HOLD with handshake; clear with accept
        for (int i = 0; i < 4; i++) cycle(1, DW'(3), 0, 0, 0);
        cycle(0, '0, 0, 1, 1);
        cycle(1, DW'(40), 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, DW'(10 + i), 0, 0, 1);
        idle(2, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            d = {1'($urandom), 32'($urandom)};
            if ($urandom_range(0, 7) == 0) d = mx;
            cycle($urandom_range(0, 3) != 0, d,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 31) == 0,
                  $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        idle(4, 1);
        chk("sb_empty", 64'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
